// File: rtl/up_counter_ctrl.sv
// -----------------------------------------------------------------------------
// up_counter_ctrl
//
// Run/stop/clear controller for the 0..MAX_COUNT up-counter that feeds
// fnd_controller's counter[13:0] input. It detects rising edges on the
// debounced button levels and runs a STOP/RUN/CLEAR state machine. While
// running, it divides the system clock down to TICK_HZ and advances the
// 14-bit count on every tick, wrapping at MAX_COUNT.
//
// Optional feature, macro UP_COUNTER_CTRL_DIR_EN:
//   When defined, a rising edge on btn_mode toggles the count direction
//   (o_dir). When undefined, btn_mode is ignored and the block counts up only.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   TICK_HZ    count rate in Hz; DIV = CLK_FREQ/TICK_HZ must be >= 2
//   MAX_COUNT  last value before wrapping to 0 (<= 16383)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   btn_run_stop  debounced level; rising edge toggles run/stop
//   btn_clear     debounced level; rising edge clears the count while stopped
//   btn_mode      debounced level; rising edge toggles direction (macro only)
//   counter       current count value
//   o_run         1 while the FSM is in RUN
//   o_tick        one-cycle pulse coincident with a tick-driven count update
//   o_dir         0 = up, 1 = down (tied 0 without the macro)
// -----------------------------------------------------------------------------
module up_counter_ctrl #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run_stop,
    input  logic        btn_clear,
    input  logic        btn_mode,
    output logic [13:0] counter,
    output logic        o_run,
    output logic        o_tick,
    output logic        o_dir
);

    localparam int              DIV      = CLK_FREQ / TICK_HZ;
    localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [13:0]     MAX_VAL  = 14'(MAX_COUNT);

    // Button vector bit positions
    localparam int BTN_RUN = 0;
    localparam int BTN_CLR = 1;

`ifdef UP_COUNTER_CTRL_DIR_EN
    localparam int BTN_MODE = 2;
    localparam int NBTN     = 3;
`else
    localparam int NBTN     = 2;
`endif

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    logic [NBTN-1:0]  btn_vec;
    logic [NBTN-1:0]  prev_reg;
    logic [NBTN-1:0]  edge_vec;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [13:0]      count_reg, count_next;
    logic             run_reg;
    logic             tick_reg;
    logic             tick;
    logic             dir_down;

`ifdef UP_COUNTER_CTRL_DIR_EN
    assign btn_vec = {btn_mode, btn_clear, btn_run_stop};
`else
    assign btn_vec = {btn_clear, btn_run_stop};
    // btn_mode has no function in the up-only build
    logic unused_btn_mode;
    assign unused_btn_mode = btn_mode;
`endif

    // Rising-edge detect: one edge per low-to-high level transition. History
    // resets to 0, so a button already high at reset release gives one edge.
    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_edge
            assign edge_vec[gi] = btn_vec[gi] & ~prev_reg[gi];
        end
    endgenerate

    // Tick only while running; the divider restarts from 0 on every RUN entry
    assign tick = (state_reg == ST_RUN) && (div_reg == DIV_LAST);

    // Next-state logic. Clear wins over run_stop in STOP; all edges are
    // dropped during the single CLEAR cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_STOP: begin
                if (edge_vec[BTN_CLR])
                    state_next = ST_CLEAR;
                else if (edge_vec[BTN_RUN])
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (edge_vec[BTN_RUN])
                    state_next = ST_STOP;
            end
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    // Divider and count datapath
    always_comb begin
        div_next   = '0;
        count_next = count_reg;
        if (state_reg == ST_RUN && !tick)
            div_next = div_reg + 1'b1;

        if (state_reg == ST_CLEAR) begin
            count_next = '0;
        end else if (tick) begin
            // A tick coincident with a stop edge still advances the count
            if (dir_down)
                count_next = (count_reg == 14'd0) ? MAX_VAL : count_reg - 14'd1;
            else
                count_next = (count_reg == MAX_VAL) ? 14'd0 : count_reg + 14'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_reg  <= '0;
            state_reg <= ST_STOP;
            div_reg   <= '0;
            count_reg <= '0;
            run_reg   <= 1'b0;
            tick_reg  <= 1'b0;
        end else begin
            prev_reg  <= btn_vec;
            state_reg <= state_next;
            div_reg   <= div_next;
            count_reg <= count_next;
            run_reg   <= (state_next == ST_RUN);
            tick_reg  <= tick;
        end
    end

`ifdef UP_COUNTER_CTRL_DIR_EN
    logic dir_reg, dir_next;

    // Direction applies from the next tick: the current tick uses dir_reg
    always_comb begin
        dir_next = dir_reg;
        if (edge_vec[BTN_MODE] && state_reg != ST_CLEAR)
            dir_next = ~dir_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            dir_reg <= 1'b0;
        else
            dir_reg <= dir_next;
    end

    assign dir_down = dir_reg;
    assign o_dir    = dir_reg;
`else
    assign dir_down = 1'b0;
    assign o_dir    = 1'b0;
`endif

    assign counter = count_reg;
    assign o_run   = run_reg;
    assign o_tick  = tick_reg;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_up_counter_ctrl
//
// Directed bench for up_counter_ctrl with CLK_FREQ=100, TICK_HZ=10 (DIV=10)
// and MAX_COUNT=12. Stimulus pushes each expected tick (cycle, count value,
// direction) into a queue; a monitor pops and compares whenever o_tick is
// seen, and flags ticks that are unexpected or missing.
// -----------------------------------------------------------------------------
module tb_up_counter_ctrl;

    localparam int DIV  = 10;
    localparam int MAXC = 12;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic        btn_run_stop = 1'b0;
    logic        btn_clear    = 1'b0;
    logic        btn_mode     = 1'b0;
    logic [13:0] counter;
    logic        o_run;
    logic        o_tick;
    logic        o_dir;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int cnt;
        bit dir;
    } tick_t;

    tick_t exp_q[$];
    tick_t mon_e;
    int    exp_count = 0;
    bit    exp_dir   = 1'b0;
    int    run_start = 0;
    int    next_tick = 0;

    up_counter_ctrl #(
        .CLK_FREQ  (100),
        .TICK_HZ   (10),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .btn_mode     (btn_mode),
        .counter      (counter),
        .o_run        (o_run),
        .o_tick       (o_tick),
        .o_dir        (o_dir)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; read on falling edges only
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_tick: no o_tick at cycle %0d, required tick with counter=%0d",
                     mon_e.cyc, mon_e.cnt);
        end
        if (o_tick) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: o_tick=1 at cycle %0d counter=%0d, required o_tick=0",
                         cyc, counter);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_cycle", cyc, mon_e.cyc);
                check("tick_counter", int'(counter), mon_e.cnt);
                check("tick_dir", int'(o_dir), int'(mon_e.dir));
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_run();
        @(negedge clk);
        btn_run_stop = 1'b1;
        @(negedge clk);
        btn_run_stop = 1'b0;
    endtask

    // run_start is the rising edge that sampled the run edge
    task automatic start_run();
        pulse_run();
        run_start = cyc;
        next_tick = run_start + DIV;
    endtask

    task automatic expect_ticks(input int n);
        tick_t t;
        for (int k = 0; k < n; k++) begin
            if (exp_dir)
                exp_count = (exp_count == 0) ? MAXC : exp_count - 1;
            else
                exp_count = (exp_count == MAXC) ? 0 : exp_count + 1;
            t.cyc = next_tick;
            t.cnt = exp_count;
            t.dir = exp_dir;
            exp_q.push_back(t);
            next_tick += DIV;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_counter", int'(counter), 0);
        check("rst_o_run", int'(o_run), 0);
        check("rst_o_tick", int'(o_tick), 0);
        check("rst_o_dir", int'(o_dir), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_counter", int'(counter), 0);

        // Test 1: run, first tick after DIV cycles, 5 after 50 cycles
        start_run();
        expect_ticks(5);
        wait_until(run_start + 3);
        check("t1_o_run", int'(o_run), 1);
        wait_until(run_start + 5*DIV + 2);
        check("t1_counter_50", int'(counter), 5);

        // Test 2: clear held in RUN is ignored; stop freezes; clear zeroes
        expect_ticks(4);
        wait_until(run_start + 7*DIV + 1);
        check("t2_counter_7", int'(counter), 7);
        btn_clear = 1'b1;
        repeat (20) @(negedge clk);
        btn_clear = 1'b0;
        check("t2_run_after_clear_hold", int'(o_run), 1);
        wait_until(run_start + 9*DIV + 3);
        pulse_run();
        wait_until(run_start + 12*DIV);
        check("t2_frozen_counter", int'(counter), 9);
        check("t2_stopped", int'(o_run), 0);
        @(negedge clk);
        btn_clear = 1'b1;
        @(negedge clk);
        btn_clear = 1'b0;
        check("t2_counter_in_clear", int'(counter), 9);
        @(negedge clk);
        check("t2_counter_cleared", int'(counter), 0);
        check("t2_o_run_cleared", int'(o_run), 0);
        exp_count = 0;

        // Test 3: wrap at MAX_COUNT=12, then 5 more ticks
        start_run();
        expect_ticks(13);
        wait_until(run_start + 13*DIV + 2);
        check("t3_wrap_to_0", int'(counter), 0);
        expect_ticks(5);
        wait_until(run_start + 18*DIV + 2);
        pulse_run();
        repeat (5) @(negedge clk);
        check("t3_counter_5", int'(counter), 5);
        check("t3_stopped", int'(o_run), 0);

        // Test 4: clear and run_stop together in STOP -> clear wins
        @(negedge clk);
        btn_clear    = 1'b1;
        btn_run_stop = 1'b1;
        @(negedge clk);
        btn_clear    = 1'b0;
        btn_run_stop = 1'b0;
        check("t4_o_run_in_clear", int'(o_run), 0);
        @(negedge clk);
        check("t4_counter_cleared", int'(counter), 0);
        exp_count = 0;
        repeat (25) @(negedge clk);
        check("t4_o_run_stays_0", int'(o_run), 0);
        check("t4_counter_stays_0", int'(counter), 0);

        // Test 5: asynchronous reset mid-run at divider=5
        start_run();
        expect_ticks(2);
        wait_until(run_start + 2*DIV + 5);
        check("t5_counter_before_rst", int'(counter), 2);
        reset = 1'b0;
        #1;
        check("t5_async_counter", int'(counter), 0);
        check("t5_async_o_run", int'(o_run), 0);
        @(negedge clk);
        reset = 1'b1;
        exp_count = 0;
        repeat (40) @(negedge clk);
        check("t5_no_run_after_rst", int'(o_run), 0);
        check("t5_counter_after_rst", int'(counter), 0);

        // Test 6: direction control
        @(negedge clk);
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        @(negedge clk);
`ifdef UP_COUNTER_CTRL_DIR_EN
        check("t6_o_dir_down", int'(o_dir), 1);
        exp_dir = 1'b1;
        start_run();
        expect_ticks(2);
        wait_until(run_start + 2*DIV + 2);
        pulse_run();
        repeat (3) @(negedge clk);
        check("t6_counter_down", int'(counter), MAXC - 1);
`else
        check("t6_o_dir_fixed_up", int'(o_dir), 0);
        start_run();
        expect_ticks(2);
        wait_until(run_start + 2*DIV + 2);
        pulse_run();
        repeat (3) @(negedge clk);
        check("t6_counter_up", int'(counter), 2);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
